// File: rtl/nap_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : nap_pkg
// Brief    : Shared state encoding, BCD time type and legality check for the nap sequencer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package nap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SLEEP  = 3'd1,
        ST_ALARM  = 3'd2,
        ST_SNOOZE = 3'd3,
        ST_DONE   = 3'd4
    } nap_state_t;

    typedef struct packed {
        logic [3:0] h10;
        logic [3:0] h1;
        logic [3:0] m10;
        logic [3:0] m1;
        logic [3:0] s10;
        logic [3:0] s1;
    } bcd_time_t;

    localparam bcd_time_t BCD_ZERO = '0;

    // Valid 24-hour clock reading, excluding the empty duration.
    function automatic logic bcd_time_legal(input bcd_time_t t);
        logic ok;
        ok = (t.h10 <= 4'd2) && (t.h1 <= 4'd9) && (t.m10 <= 4'd5) &&
             (t.m1 <= 4'd9) && (t.s10 <= 4'd5) && (t.s1 <= 4'd9);
        if ((t.h10 == 4'd2) && (t.h1 > 4'd3)) begin
            ok = 1'b0;
        end
        if (t == BCD_ZERO) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_time_dec.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : bcd_time_dec
// Brief    : Combinational hh:mm:ss BCD decrement by one second, with zero flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module bcd_time_dec
    import nap_pkg::*;
(
    input  logic [23:0] value,
    output logic [23:0] result,
    output logic        is_zero
);

    logic [5:0] w_borrow;

    assign w_borrow[0] = 1'b1;

    // Digit 0 is s1; tens-of-seconds and tens-of-minutes wrap to 5.
    for (genvar i = 0; i < 6; i++) begin : g_digit
        localparam logic [3:0] c_digit_max = ((i == 1) || (i == 3)) ? 4'd5 : 4'd9;
        logic [3:0] w_digit;

        assign w_digit = value[4*i +: 4];
        assign result[4*i +: 4] = !w_borrow[i]       ? w_digit :
                                  (w_digit == 4'd0)  ? c_digit_max :
                                                       (w_digit - 4'd1);
        if (i < 5) begin : g_chain
            assign w_borrow[i+1] = w_borrow[i] && (w_digit == 4'd0);
        end
    end

    assign is_zero = (result == BCD_ZERO);

endmodule
`default_nettype wire

// File: rtl/nap_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : nap_sequencer
// Brief    : Nap countdown in real seconds with alarm, bounded snooze, timeout and cancel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module nap_sequencer
    import nap_pkg::*;
#(
    parameter int CLK_PER_SEC       = 1000000,
    parameter int SNOOZE_MIN        = 5,
    parameter int MAX_SNOOZE        = 3,
    parameter int ALARM_TIMEOUT_SEC = 60
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] set_time,
    input  logic        start,
    input  logic        cancel,
    input  logic        snooze,
    input  logic        ack,
    output logic [23:0] remaining,
    output logic        en_sleep,
    output logic        en_snooze,
    output logic        en_alarm,
    output logic        done,
    output logic        missed,
    output logic        err_time,
    output logic        sec_pulse,
    output logic [3:0]  snooze_left
);

    localparam int              c_ps_w        = $clog2(CLK_PER_SEC);
    localparam logic [c_ps_w-1:0] c_ps_last   = c_ps_w'(CLK_PER_SEC - 1);
    localparam logic [3:0]      c_max_snooze  = 4'(MAX_SNOOZE);
    localparam logic [7:0]      c_timeout     = 8'(ALARM_TIMEOUT_SEC);
    localparam logic [23:0]     c_snooze_time = {8'h00, 4'(SNOOZE_MIN / 10),
                                                 4'(SNOOZE_MIN % 10), 8'h00};

    nap_state_t        r_state;
    logic [23:0]       r_remaining;
    logic [3:0]        r_snooze_left;
    logic [c_ps_w-1:0] r_presc;
    logic [7:0]        r_alarm_cnt;
    logic              r_missed;
    logic              r_err_time;
    logic              r_sec_pulse;

    nap_state_t        w_state_nxt;
    logic [23:0]       w_remaining_nxt;
    logic [3:0]        w_snooze_left_nxt;
    logic [c_ps_w-1:0] w_presc_nxt;
    logic [7:0]        w_alarm_cnt_nxt;
    logic              w_missed_nxt;
    logic              w_err_time_nxt;
    logic              w_sec_pulse_nxt;

    logic [23:0]       w_dec;
    logic              w_dec_zero;
    logic              w_tick;
    logic              w_set_legal;
    logic [7:0]        w_alarm_inc;

    bcd_time_dec u_dec (
        .value   (r_remaining),
        .result  (w_dec),
        .is_zero (w_dec_zero)
    );

    assign w_tick      = (r_presc == c_ps_last);
    assign w_set_legal = bcd_time_legal(set_time);
    assign w_alarm_inc = r_alarm_cnt + 8'd1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_remaining   <= '0;
            r_snooze_left <= '0;
            r_presc       <= '0;
            r_alarm_cnt   <= '0;
            r_missed      <= 1'b0;
            r_err_time    <= 1'b0;
            r_sec_pulse   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_remaining   <= w_remaining_nxt;
            r_snooze_left <= w_snooze_left_nxt;
            r_presc       <= w_presc_nxt;
            r_alarm_cnt   <= w_alarm_cnt_nxt;
            r_missed      <= w_missed_nxt;
            r_err_time    <= w_err_time_nxt;
            r_sec_pulse   <= w_sec_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_remaining_nxt   = r_remaining;
        w_snooze_left_nxt = r_snooze_left;
        w_presc_nxt       = r_presc;
        w_alarm_cnt_nxt   = r_alarm_cnt;
        w_missed_nxt      = r_missed;
        w_err_time_nxt    = 1'b0;
        w_sec_pulse_nxt   = 1'b0;

        if (cancel) begin
            w_state_nxt       = ST_IDLE;
            w_remaining_nxt   = '0;
            w_snooze_left_nxt = '0;
            w_presc_nxt       = '0;
            w_alarm_cnt_nxt   = '0;
            w_missed_nxt      = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (w_set_legal) begin
                            w_state_nxt       = ST_SLEEP;
                            w_remaining_nxt   = set_time;
                            w_snooze_left_nxt = c_max_snooze;
                            w_presc_nxt       = '0;
                            w_missed_nxt      = 1'b0;
                        end else begin
                            w_err_time_nxt    = 1'b1;
                        end
                    end
                end
                ST_SLEEP, ST_SNOOZE: begin
                    if (w_tick) begin
                        w_presc_nxt     = '0;
                        w_remaining_nxt = w_dec;
                        w_sec_pulse_nxt = 1'b1;
                        // Zero is judged on the freshly decremented value.
                        if (w_dec_zero) begin
                            w_state_nxt     = ST_ALARM;
                            w_alarm_cnt_nxt = '0;
                        end
                    end else begin
                        w_presc_nxt = r_presc + c_ps_w'(1);
                    end
                end
                ST_ALARM: begin
                    w_presc_nxt = w_tick ? '0 : (r_presc + c_ps_w'(1));
                    if (ack) begin
                        w_state_nxt  = ST_DONE;
                        w_missed_nxt = 1'b0;
                    end else if (snooze && (r_snooze_left != 4'd0)) begin
                        w_state_nxt       = ST_SNOOZE;
                        w_snooze_left_nxt = r_snooze_left - 4'd1;
                        w_remaining_nxt   = c_snooze_time;
                        w_presc_nxt       = '0;
                    end else if (w_tick) begin
                        if (w_alarm_inc == c_timeout) begin
                            w_state_nxt  = ST_DONE;
                            w_missed_nxt = 1'b1;
                        end else begin
                            w_alarm_cnt_nxt = w_alarm_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign remaining   = r_remaining;
    assign en_sleep    = (r_state == ST_SLEEP);
    assign en_snooze   = (r_state == ST_SNOOZE);
    assign en_alarm    = (r_state == ST_ALARM);
    assign done        = (r_state == ST_DONE);
    assign missed      = r_missed;
    assign err_time    = r_err_time;
    assign sec_pulse   = r_sec_pulse;
    assign snooze_left = r_snooze_left;

endmodule
`default_nettype wire

// File: doc/nap_sequencer.md
# nap_sequencer

Parametrised nap-cycle controller: loads a BCD hh:mm:ss nap duration, counts it down in real seconds, raises an alarm, and supports a bounded number of snoozes, alarm auto-timeout and cancel. It replaces the fixed sleep/alarm/cancel path of the nap machine. Its outputs drive the 7-segment time display, the lullaby and alarm sound engines, and the RGB light blocks.

## Interface
Parameters:
- CLK_PER_SEC, 1000000, clock cycles per counted second (must be ≥ 2)
- SNOOZE_MIN, 5, snooze length in minutes (1–59)
- MAX_SNOOZE, 3, snoozes allowed per nap (0–15)
- ALARM_TIMEOUT_SEC, 60, seconds the alarm rings before auto-stop (1–255)

Ports:
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-low reset
- set_time  in  24  BCD {h10,h1,m10,m1,s10,s1}, sampled on start
- start  in  1  one-cycle pulse: begin nap
- cancel  in  1  one-cycle pulse: abort to idle
- snooze  in  1  one-cycle pulse: snooze while alarming
- ack  in  1  one-cycle pulse: wake confirmed
- remaining  out  24  BCD time left
- en_sleep  out  1  nap countdown active
- en_snooze  out  1  snooze countdown active
- en_alarm  out  1  alarm ringing
- done  out  1  nap finished (held)
- missed  out  1  finished by timeout, not ack (held with done)
- err_time  out  1  one-cycle pulse: start rejected
- sec_pulse  out  1  one-cycle pulse on each decrement
- snooze_left  out  4  snoozes remaining

## Operation
- States: IDLE, SLEEP, ALARM, SNOOZE, DONE. Mode outputs are decoded directly from the state register. At most one of en_sleep/en_snooze/en_alarm/done is high.
- Legal time: h10≤2; h1≤9 (≤3 when h10=2); m10≤5; s10≤5; each digit ≤9; not 00:00:00.
- IDLE or DONE, start:
  - Legal time → load remaining=set_time, snooze_left=MAX_SNOOZE, clear prescaler, clear done/missed, go to SLEEP.
  - Illegal time → err_time pulse; state and outputs unchanged.
- SLEEP/SNOOZE:
  - Prescaler counts 0..CLK_PER_SEC-1. On terminal count, remaining is BCD-decremented with borrow (s1→s10 0–5→m1→m10 0–5→h1→h10) and sec_pulse fires.
  - When remaining becomes 00:00:00 → ALARM, alarm second counter=0.
- ALARM:
  - Prescaler keeps running and increments the alarm second counter.
  - ack → DONE, missed=0.
  - snooze with snooze_left>0 → SNOOZE, snooze_left−1, remaining=00:SNOOZE_MIN:00, prescaler cleared.
  - snooze with snooze_left=0 → ignored.
  - Counter reaching ALARM_TIMEOUT_SEC → DONE, missed=1.
- cancel in any state → IDLE: remaining=0, snooze_left=0, done=missed=0.
- Priority when pulses coincide: cancel > ack > snooze > timeout. start is ignored outside IDLE/DONE.
- The alarm second counter is 8-bit.

## Timing
- Reset (reset=0 at an edge): state IDLE; all outputs 0, including remaining, snooze_left and the pulses. Prescaler and alarm counter are 0. Reset mid-nap aborts silently; there is no alarm.
- start sampled at edge N:
  - State/outputs are valid after edge N+1.
  - First decrement at edge N+CLK_PER_SEC.
  - Nap of T seconds: en_alarm rises at edge N+T·CLK_PER_SEC.
- Zero detection uses the decremented value, so ALARM is entered on the same edge that writes 00:00:00.
- Snooze at edge M: en_snooze high from M; first decrement at M+CLK_PER_SEC.
- Timeout: DONE is entered on the edge at which the counter would reach ALARM_TIMEOUT_SEC.
- err_time and sec_pulse are exactly one cycle wide and registered.

## Structure
- Shared package nap_pkg:
  - state enum nap_state_t
  - bcd_time_t (24-bit packed, 6 digits)
  - constant BCD_ZERO
  - function bcd_time_legal
- Sub-module bcd_time_dec: combinational 6-digit BCD decrement with borrow, plus is_zero flag on the result. Reusable by the display/timer blocks.
- Prescaler, alarm counter and FSM live in the top module.

## Test plan
Run with CLK_PER_SEC=4, SNOOZE_MIN=1, MAX_SNOOZE=1, ALARM_TIMEOUT_SEC=3.

1. start, set_time=00:00:03 at edge 10 → decrements at edges 14, 18, 22; en_alarm rises at edge 22 with remaining=000000.
2. Decrement from 01:00:00 → next value is 00:59:59; from 10:00:00 → 09:59:59.
3. In ALARM, snooze → en_snooze=1, remaining=00:01:00, snooze_left=0. At next alarm, snooze is ignored; after 3 s → done=1, missed=1.
4. In ALARM, ack and snooze on the same cycle → DONE, missed=0, snooze_left unchanged.
5. set_time=24:00:00, 00:60:00 or 00:00:00 → err_time pulses once; state stays IDLE.
6. reset=0 mid-SLEEP → next cycle all outputs 0, IDLE. cancel during SNOOZE → IDLE, remaining=0.
